// File: rtl/sdram_te_pkg.sv
// -----------------------------------------------------------------------------
// sdram_te_pkg
// Shared definitions for the SDRAM timing engine:
//   - cmd_id codes that select a delay
//   - the delay-counter FSM state type
//   - width constants for cmd_id and the refresh credit
//   - te_delay(): delay normalisation. The value is truncated to the counter
//     width, and a result of 0 becomes 1.
// -----------------------------------------------------------------------------
package sdram_te_pkg;

   localparam int CMD_W    = 3;
   localparam int CREDIT_W = 4;

   // Delay selectors. CMD_WR times the write burst plus write recovery
   // (W_BL + TDAL), so the FSM can issue the next ACTIVE/REFRESH after done.
   typedef enum logic [CMD_W-1:0] {
      CMD_TRP  = 3'd0,
      CMD_TRFC = 3'd1,
      CMD_TMRD = 3'd2,
      CMD_TRCD = 3'd3,
      CMD_TCL  = 3'd4,
      CMD_RD   = 3'd5,
      CMD_WR   = 3'd6,
      CMD_RSVD = 3'd7
   } cmd_id_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } te_state_e;

   // Truncate a cycle count to cnt_w bits. A resulting zero becomes one, so
   // every accepted command produces at least one busy cycle.
   function automatic int unsigned te_delay(input int unsigned cyc,
                                            input int unsigned cnt_w);
      int unsigned t;
      t = cyc & ((32'd1 << cnt_w) - 32'd1);
      return (t == 32'd0) ? 32'd1 : t;
   endfunction

endpackage

// File: rtl/sdram_te_refsched.sv
// -----------------------------------------------------------------------------
// sdram_te_refsched
// Refresh scheduler. It holds the free-running interval counter, the count of
// owed refreshes (credit), and the urgency and overrun flags.
// Optional feature macro: SDRAM_TE_REF_POSTPONE_EN
//   defined   : credit counts 0..MAX_POSTPONE (clamped to 1..15)
//   undefined : only one refresh can be outstanding (credit 0/1)
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   ref_ack      one-cycle pulse, one refresh issued (ignored when credit is 0)
//   ref_req      at least one refresh is owed
//   ref_urgent   credit has reached MAX_POSTPONE-1 (non-postpone build: ref_req)
//   ref_overrun  sticky; an interval ticked with no room left for it
//   ref_credit   number of owed refreshes, zero-extended to 4 bits
// -----------------------------------------------------------------------------
module sdram_te_refsched
   import sdram_te_pkg::*;
#(
   parameter int T_REF_CYC    = 2000,
   parameter int MAX_POSTPONE = 8
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ref_ack,
   output logic                ref_req,
   output logic                ref_urgent,
   output logic                ref_overrun,
   output logic [CREDIT_W-1:0] ref_credit
);

`ifdef SDRAM_TE_REF_POSTPONE_EN
   localparam bit POSTPONE_EN = 1'b1;
`else
   localparam bit POSTPONE_EN = 1'b0;
`endif

   localparam int MAX_CLAMP = (MAX_POSTPONE < 1)  ? 1  :
                              (MAX_POSTPONE > 15) ? 15 : MAX_POSTPONE;
   // The single-outstanding build is the same counter with a limit of one.
   localparam int LIMIT     = POSTPONE_EN ? MAX_CLAMP : 1;
   localparam int CW        = POSTPONE_EN ? CREDIT_W : 1;
   localparam int RW        = $clog2(T_REF_CYC + 1);

   localparam logic [RW-1:0] IV_LAST = RW'(T_REF_CYC - 1);
   localparam logic [CW-1:0] CR_MAX  = CW'(LIMIT);
   localparam logic [CW-1:0] CR_URG  = CW'(LIMIT - 1);

   logic [RW-1:0] iv_q;
   logic [CW-1:0] credit_q;
   logic          tick;
   logic          ack_ok;

   assign tick   = (iv_q == IV_LAST);
   assign ack_ok = ref_ack && (credit_q != '0);

   // NOTE: sequential state uses non-blocking (<=) so every flop samples
   // pre-edge values. Reset is asynchronous; release is synchronised upstream.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         iv_q <= '0;
      end else begin
         iv_q <= tick ? '0 : iv_q + 1'b1;
      end
   end

   // A tick together with a valid ack leaves credit unchanged. Overrun means
   // an interval was truly lost: a tick arrived with credit full and no ack
   // freeing a slot in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         credit_q    <= '0;
         ref_overrun <= 1'b0;
      end else if (tick && !ack_ok) begin
         if (credit_q == CR_MAX) begin
            ref_overrun <= 1'b1;
         end else begin
            credit_q <= credit_q + 1'b1;
         end
      end else if (!tick && ack_ok) begin
         credit_q <= credit_q - 1'b1;
      end
   end

   assign ref_req    = (credit_q != '0);
   assign ref_urgent = ref_req && (credit_q >= CR_URG);
   assign ref_credit = CREDIT_W'(credit_q);

endmodule

// File: rtl/sdram_timer_engine.sv
// -----------------------------------------------------------------------------
// sdram_timer_engine
// SDRAM timing engine. One shared delay counter is loaded by command code. The
// engine also contains a power-up wait counter and the refresh scheduler
// (sdram_te_refsched).
// Optional feature macro: SDRAM_TE_REF_POSTPONE_EN (refresh credit counter).
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   cmd_start    single-cycle request to time one command
//   cmd_id       delay selector (cmd_id_e), sampled with cmd_start
//   busy         delay window active
//   done         one-cycle pulse in the last busy cycle
//   cmd_err      one-cycle pulse one cycle after a rejected cmd_start
//   init_done    sticky, power-up wait elapsed
//   ref_req, ref_urgent, ref_overrun, ref_credit, ref_ack   refresh interface
// -----------------------------------------------------------------------------
module sdram_timer_engine
   import sdram_te_pkg::*;
#(
   parameter int CNT_W        = 9,
   parameter int T_INIT_CYC   = 26667,
   parameter int T_REF_CYC    = 2000,
   parameter int MAX_POSTPONE = 8,
   parameter int TRP          = 3,
   parameter int TRFC         = 7,
   parameter int TMRD         = 2,
   parameter int TRCD         = 3,
   parameter int TCL          = 3,
   parameter int R_BL         = 8,
   parameter int W_BL         = 8,
   parameter int TDAL         = 4
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cmd_start,
   input  logic [CMD_W-1:0]    cmd_id,
   output logic                busy,
   output logic                done,
   output logic                cmd_err,
   output logic                init_done,
   output logic                ref_req,
   input  logic                ref_ack,
   output logic                ref_urgent,
   output logic                ref_overrun,
   output logic [CREDIT_W-1:0] ref_credit
);

   // Normalised delays N (1 .. 2**CNT_W-1). The counter is loaded with N-1.
   localparam logic [CNT_W-1:0] N_TRP  = CNT_W'(te_delay(TRP,         CNT_W));
   localparam logic [CNT_W-1:0] N_TRFC = CNT_W'(te_delay(TRFC,        CNT_W));
   localparam logic [CNT_W-1:0] N_TMRD = CNT_W'(te_delay(TMRD,        CNT_W));
   localparam logic [CNT_W-1:0] N_TRCD = CNT_W'(te_delay(TRCD,        CNT_W));
   localparam logic [CNT_W-1:0] N_TCL  = CNT_W'(te_delay(TCL,         CNT_W));
   localparam logic [CNT_W-1:0] N_RD   = CNT_W'(te_delay(R_BL,        CNT_W));
   localparam logic [CNT_W-1:0] N_WR   = CNT_W'(te_delay(W_BL + TDAL, CNT_W));

   localparam int            PW      = $clog2(T_INIT_CYC + 1);
   localparam logic [PW-1:0] PWR_END = PW'(T_INIT_CYC);

   te_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] dly_n;
   logic             id_valid;
   logic             accept;
   logic             err_d;
   logic [PW-1:0]    pwr_cnt_q;

   // ---------------------------------------------------------------- ID decode
   // NOTE: every always_comb output gets a default on entry, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      id_valid = 1'b1;
      dly_n    = N_TRP;
      case (cmd_id_e'(cmd_id))
         CMD_TRP:  dly_n = N_TRP;
         CMD_TRFC: dly_n = N_TRFC;
         CMD_TMRD: dly_n = N_TMRD;
         CMD_TRCD: dly_n = N_TRCD;
         CMD_TCL:  dly_n = N_TCL;
         CMD_RD:   dly_n = N_RD;
         CMD_WR:   dly_n = N_WR;
         default:  id_valid = 1'b0;
      endcase
   end

   // ------------------------------------------------------------ delay counter
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      busy    = (state_q == ST_RUN);
      done    = busy && (cnt_q == '0);
      // A new command is accepted when idle, or in the done cycle (back-to-back).
      accept  = cmd_start && id_valid && (!busy || done);
      err_d   = cmd_start && !accept;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_RUN;
               cnt_d   = dly_n - CNT_W'(1);
            end
         end
         ST_RUN: begin
            if (done) begin
               if (accept) begin
                  cnt_d = dly_n - CNT_W'(1);
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         cmd_err <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cmd_err <= err_d;
      end
   end

   // ---------------------------------------------------------- power-up wait
   // init_done is set on the same edge that brings the count to T_INIT_CYC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwr_cnt_q <= '0;
         init_done <= 1'b0;
      end else if (pwr_cnt_q != PWR_END) begin
         pwr_cnt_q <= pwr_cnt_q + 1'b1;
         if (pwr_cnt_q == PWR_END - 1'b1) begin
            init_done <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------ refresh scheduler
   sdram_te_refsched #(
      .T_REF_CYC    (T_REF_CYC),
      .MAX_POSTPONE (MAX_POSTPONE)
   ) u_refsched (
      .clk         (clk),
      .rst_n       (rst_n),
      .ref_ack     (ref_ack),
      .ref_req     (ref_req),
      .ref_urgent  (ref_urgent),
      .ref_overrun (ref_overrun),
      .ref_credit  (ref_credit)
   );

endmodule

// File: tb/tb_sdram_timer_engine.sv
// -----------------------------------------------------------------------------
// tb_sdram_timer_engine
// Self-checking bench. The reference model tracks absolute cycle numbers: the
// busy window [b_start, b_end], the cycle of the expected cmd_err pulse, and an
// integer refresh credit. Outputs are compared every cycle. Directed sequences
// cover init_done timing, back-to-back commands, rejects, postponement,
// tick/ack collision and mid-operation reset.
// -----------------------------------------------------------------------------
module tb_sdram_timer_engine;
   import sdram_te_pkg::*;

   localparam int T_INIT = 26667;
   localparam int T_REF  = 200;
`ifdef SDRAM_TE_REF_POSTPONE_EN
   localparam int MAXP   = 8;
`else
   localparam int MAXP   = 1;
`endif

   logic       clk       = 1'b0;
   logic       rst_n     = 1'b1;
   logic       cmd_start = 1'b0;
   logic [2:0] cmd_id    = 3'd0;
   logic       ref_ack   = 1'b0;
   logic       busy, done, cmd_err, init_done;
   logic       ref_req, ref_urgent, ref_overrun;
   logic [3:0] ref_credit;

   always #5 clk = ~clk;

   sdram_timer_engine #(
      .T_INIT_CYC (T_INIT),
      .T_REF_CYC  (T_REF)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cmd_start   (cmd_start),
      .cmd_id      (cmd_id),
      .busy        (busy),
      .done        (done),
      .cmd_err     (cmd_err),
      .init_done   (init_done),
      .ref_req     (ref_req),
      .ref_ack     (ref_ack),
      .ref_urgent  (ref_urgent),
      .ref_overrun (ref_overrun),
      .ref_credit  (ref_credit)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ------------------------------------------------------------ reference model
   int s;        // clock edges since reset release
   int b_start;  // first busy cycle of the current window
   int b_end;    // done cycle of the current window
   int err_at;   // cycle in which cmd_err is expected
   int credit_m;
   int ovr_m;

   function automatic int dly_of(input int id);
      case (id)
         0:       return 3;       // TRP
         1:       return 7;       // TRFC
         2:       return 2;       // TMRD
         3:       return 3;       // TRCD
         4:       return 3;       // TCL
         5:       return 8;       // R_BL
         6:       return 8 + 4;   // W_BL + TDAL
         default: return 0;
      endcase
   endfunction

   task automatic model_reset();
      s        = 0;
      b_start  = 1;
      b_end    = 0;
      err_at   = -1;
      credit_m = 0;
      ovr_m    = 0;
   endtask

   task automatic compare_all();
      int run;
      run = (s >= b_start && s <= b_end) ? 1 : 0;
      check("busy",        busy,        run);
      check("done",        done,        (run == 1 && s == b_end) ? 1 : 0);
      check("cmd_err",     cmd_err,     (s == err_at) ? 1 : 0);
      check("init_done",   init_done,   (s >= T_INIT) ? 1 : 0);
      check("ref_req",     ref_req,     (credit_m != 0) ? 1 : 0);
      check("ref_urgent",  ref_urgent,  (credit_m != 0 && credit_m >= MAXP - 1) ? 1 : 0);
      check("ref_overrun", ref_overrun, ovr_m);
      check("ref_credit",  ref_credit,  credit_m);
   endtask

   // Drive one cycle of inputs, advance the model over the edge, then compare.
   task automatic cycle(input bit st, input int id, input bit ack);
      bit run, dn, tick, ack_ok;
      cmd_start = st;
      cmd_id    = id[2:0];
      ref_ack   = ack;
      run = (s >= b_start && s <= b_end);
      dn  = run && (s == b_end);
      if (st) begin
         if (id == 7 || (run && !dn)) begin
            err_at = s + 1;
         end else begin
            b_start = s + 1;
            b_end   = s + dly_of(id);
         end
      end
      tick   = ((s % T_REF) == T_REF - 1);
      ack_ok = ack && (credit_m > 0);
      if (tick && !ack_ok) begin
         if (credit_m == MAXP) ovr_m = 1;
         else                  credit_m++;
      end else if (!tick && ack_ok) begin
         credit_m--;
      end
      @(posedge clk);
      s++;
      #1;
      cmd_start = 1'b0;
      ref_ack   = 1'b0;
      compare_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 0, 1'b0);
   endtask

   // Assert reset away from a clock edge, check the outputs clear at once,
   // then release and restart the model at cycle 0.
   task automatic apply_reset(input string tag);
      rst_n = 1'b0;
      #1;
      check({tag, "_rst_busy"},   busy,        0);
      check({tag, "_rst_done"},   done,        0);
      check({tag, "_rst_err"},    cmd_err,     0);
      check({tag, "_rst_init"},   init_done,   0);
      check({tag, "_rst_req"},    ref_req,     0);
      check({tag, "_rst_urg"},    ref_urgent,  0);
      check({tag, "_rst_ovr"},    ref_overrun, 0);
      check({tag, "_rst_credit"}, ref_credit,  0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      compare_all();
   endtask

   initial begin
      int n5;
      model_reset();
      #2;
      apply_reset("t0");

      // Randomised traffic across the whole power-up wait (init_done edge).
      for (int i = 0; i < T_INIT + 400; i++) begin
         bit st, ack;
         int id;
         st  = ($urandom_range(3) == 0);
         id  = $urandom_range(7);
         ack = (i < T_INIT / 2) ? ($urandom_range(399) == 0) : ($urandom_range(59) == 0);
         cycle(st, id, ack);
      end
      check("t1_init_sticky", init_done, 1);

      // Reset mid-RUN with credit built up.
      apply_reset("t6a");
      idle(5 * T_REF);
      cycle(1'b1, CMD_TRFC, 1'b0);
      idle(2);
      check("t6_busy_pre", busy, 1);
      apply_reset("t6");
      idle(T_REF - 1);
      check("t6_no_tick_yet", ref_req, 0);
      idle(1);
      check("t6_first_tick", ref_req, 1);

      // Postponement build-up without acks.
      apply_reset("t4");
`ifdef SDRAM_TE_REF_POSTPONE_EN
      idle(6 * T_REF);
      check("t4_urg_at6", ref_urgent, 0);
      idle(T_REF);
      check("t4_credit7", ref_credit, 7);
      check("t4_urg_at7", ref_urgent, 1);
      idle(T_REF);
      check("t4_credit8", ref_credit, 8);
      check("t4_no_ovr8", ref_overrun, 0);
      idle(T_REF);
      check("t4_credit_sat", ref_credit, 8);
      check("t4_ovr9", ref_overrun, 1);
`else
      idle(T_REF);
      check("t4_credit1", ref_credit, 1);
      check("t4_urg1", ref_urgent, 1);
      check("t4_no_ovr1", ref_overrun, 0);
      idle(T_REF);
      check("t4_ovr2", ref_overrun, 1);
`endif
      for (int i = 0; i < MAXP; i++) cycle(1'b0, 0, 1'b1);
      check("t4_drained", ref_credit, 0);
      check("t4_req_low", ref_req, 0);

      // Ack coincident with a tick.
      apply_reset("t5");
`ifdef SDRAM_TE_REF_POSTPONE_EN
      n5 = 3;
`else
      n5 = 1;
`endif
      idle((n5 + 1) * T_REF - 1);
      cycle(1'b0, 0, 1'b1);
      check("t5_credit_hold", ref_credit, n5);
      check("t5_req_hold", ref_req, 1);
      check("t5_no_ovr", ref_overrun, 0);

      // TRFC, then TRP back-to-back in the done cycle.
      cycle(1'b1, CMD_TRFC, 1'b0);
      idle(6);
      check("t2_done7", done, 1);
      cycle(1'b1, CMD_TRP, 1'b0);
      check("t2_no_gap", busy, 1);
      check("t2_done_clr", done, 0);
      idle(2);
      check("t2_trp_done", done, 1);
      idle(1);
      check("t2_idle", busy, 0);

      // Reject mid-TRCD, then an invalid ID while idle.
      cycle(1'b1, CMD_TRCD, 1'b0);
      cycle(1'b1, CMD_TMRD, 1'b0);
      check("t3_err_busy", cmd_err, 1);
      idle(1);
      check("t3_trcd_done", done, 1);
      idle(1);
      cycle(1'b1, 7, 1'b0);
      check("t3_err_id7", cmd_err, 1);
      check("t3_no_start", busy, 0);
      idle(4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
